// File: rtl/usb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : usb_uart_tx_arbiter
// Purpose  : Round-robin arbiter that merges two byte streams (A = terminal,
//            B = debug/status) into the single device-to-host pipeline of a
//            USB UART core. A grant ends on a newline, at a burst limit, or
//            after an idle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module usb_uart_tx_arbiter #(
    parameter int unsigned MAX_BURST    = 64,
    parameter int unsigned IDLE_TIMEOUT = 4800,
    parameter int unsigned LINE_LOCK    = 1
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic [7:0] a_data,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [7:0] b_data,
    input  logic       b_valid,
    output logic       b_ready,
    output logic [7:0] uart_in_data,
    output logic       uart_in_valid,
    input  logic       uart_in_ready,
    output logic [1:0] grant,
    output logic [1:0] release_cause
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_A = 2'd1,
        S_GNT_B = 2'd2
    } state_t;

    localparam logic [7:0]  c_newline     = 8'h0A;
    localparam logic [8:0]  c_max_burst   = 9'(MAX_BURST);
    localparam logic [16:0] c_idle_last   = 17'(IDLE_TIMEOUT - 1);
    localparam bit          c_line_lock   = (LINE_LOCK != 0);
    localparam logic [1:0]  c_cause_nl    = 2'b01;
    localparam logic [1:0]  c_cause_burst = 2'b10;
    localparam logic [1:0]  c_cause_tmo   = 2'b11;

    state_t      state_q;
    logic [1:0]  grant_q;
    logic [1:0]  cause_q;
    logic [7:0]  burst_q;
    logic [7:0]  burst_d;
    logic [15:0] idle_q;
    logic [15:0] idle_d;
    logic        last_b_q;    // 1 when B was the most recently released owner

    logic [7:0]  sel_data;
    logic        sel_valid;
    logic        granted;
    logic        xfer;
    logic        hit_nl;
    logic        hit_burst;
    logic        hit_tmo;

    // Route the owner's stream straight through to the UART pipeline
    always_comb begin
        sel_data  = 8'h00;
        sel_valid = 1'b0;
        case (state_q)
            S_GNT_A: begin
                sel_data  = a_data;
                sel_valid = a_valid;
            end
            S_GNT_B: begin
                sel_data  = b_data;
                sel_valid = b_valid;
            end
            default: begin
                sel_data  = 8'h00;
                sel_valid = 1'b0;
            end
        endcase
    end

    assign granted       = (state_q != S_IDLE);
    assign uart_in_data  = sel_data;
    assign uart_in_valid = sel_valid;
    assign a_ready       = (state_q == S_GNT_A) && uart_in_ready;
    assign b_ready       = (state_q == S_GNT_B) && uart_in_ready;
    assign grant         = grant_q;
    assign release_cause = cause_q;

    // Release conditions evaluated on the cycle that closes at the next edge
    assign xfer      = granted && sel_valid && uart_in_ready;
    assign hit_nl    = c_line_lock && xfer && (sel_data == c_newline);
    assign hit_burst = xfer && (({1'b0, burst_q} + 9'd1) == c_max_burst);
    assign hit_tmo   = granted && !sel_valid && ({1'b0, idle_q} >= c_idle_last);

    // Counter next-state: burst counts transfers, idle saturates while starved
    always_comb begin
        burst_d = xfer ? (burst_q + 8'd1) : burst_q;
        idle_d  = idle_q;
        if (sel_valid) begin
            idle_d = 16'd0;
        end else if (idle_q != 16'hFFFF) begin
            idle_d = idle_q + 16'd1;
        end
    end

    // Arbitration FSM with registered grant, cause and round-robin pointer
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q  <= S_IDLE;
            grant_q  <= 2'b00;
            cause_q  <= 2'b00;
            burst_q  <= 8'd0;
            idle_q   <= 16'd0;
            last_b_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    burst_q <= 8'd0;
                    idle_q  <= 16'd0;
                    if (a_valid && (!b_valid || last_b_q)) begin
                        state_q <= S_GNT_A;
                        grant_q <= 2'b01;
                    end else if (b_valid) begin
                        state_q <= S_GNT_B;
                        grant_q <= 2'b10;
                    end
                end
                default: begin
                    if (hit_nl || hit_burst || hit_tmo) begin
                        state_q  <= S_IDLE;
                        grant_q  <= 2'b00;
                        last_b_q <= (state_q == S_GNT_B);
                        burst_q  <= 8'd0;
                        idle_q   <= 16'd0;
                        // Newline wins over burst limit when both land together
                        if (hit_nl) begin
                            cause_q <= c_cause_nl;
                        end else if (hit_burst) begin
                            cause_q <= c_cause_burst;
                        end else begin
                            cause_q <= c_cause_tmo;
                        end
                    end else begin
                        burst_q <= burst_d;
                        idle_q  <= idle_d;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_uart_tx_arbiter
// Purpose  : Scoreboard bench for usb_uart_tx_arbiter with a behavioural
//            grant/release model and per-requester expected byte queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_uart_tx_arbiter;

    localparam int MAXB = 64;
    localparam int TOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a_data = 8'h00;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [7:0] b_data = 8'h00;
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [7:0] uart_in_data;
    logic       uart_in_valid;
    logic       uart_in_ready = 1'b0;
    logic [1:0] grant;
    logic [1:0] release_cause;

    usb_uart_tx_arbiter #(
        .MAX_BURST   (MAXB),
        .IDLE_TIMEOUT(TOUT),
        .LINE_LOCK   (1)
    ) dut (
        .clk_48mhz    (clk),
        .reset        (reset),
        .a_data       (a_data),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .b_data       (b_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .uart_in_data (uart_in_data),
        .uart_in_valid(uart_in_valid),
        .uart_in_ready(uart_in_ready),
        .grant        (grant),
        .release_cause(release_cause)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] src_a[$];
    logic [7:0] src_b[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    int rate_a = 100;
    int rate_b = 100;
    int rdy_mode = 1;      // 0 = never ready, 1 = always ready, 2 = random
    bit acc_a = 0;
    bit acc_b = 0;

    // Behavioural model: owner 0 = none, 1 = A, 2 = B
    int         m_owner = 0;
    bit         m_last_b = 1;
    logic [1:0] m_cause = 2'b00;
    int         m_burst = 0;
    int         m_idle = 0;
    bit         m_init = 0;
    int         rel_cnt[4] = '{0, 0, 0, 0};
    logic [1:0] prev_grant = 2'b00;
    bit         prev_rst = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push_a(input logic [7:0] d);
        src_a.push_back(d);
        exp_a.push_back(d);
    endtask

    task automatic push_b(input logic [7:0] d);
        src_b.push_back(d);
        exp_b.push_back(d);
    endtask

    function automatic logic [7:0] rnd_plain();
        logic [7:0] v;
        v = 8'($urandom_range(255));
        if (v == 8'h0A) v = 8'h0B;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((src_a.size() != 0 || src_b.size() != 0 || m_owner != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s drain_timeout actual=%0d required<%0d", name, n, budget);
        end
        step(2);
    endtask

    task automatic wait_grant(input logic [1:0] g, input string name);
        int n;
        n = 0;
        while (grant !== g && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL %s grant_wait actual=%0h required=%0h", name, grant, g);
        end
    endtask

    // Monitor: compare DUT against the model, score transfers, advance model
    always @(negedge clk) begin : monitor
        logic [1:0] eg;
        logic       xv;
        logic [7:0] xd;
        bit         xfer;
        logic [7:0] e;
        acc_a = (a_valid && a_ready) === 1'b1;
        acc_b = (b_valid && b_ready) === 1'b1;
        eg = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        xv = (m_owner == 1) ? a_valid : (m_owner == 2) ? b_valid : 1'b0;
        xd = (m_owner == 1) ? a_data : (m_owner == 2) ? b_data : 8'h00;
        xfer = (m_owner != 0) && xv && uart_in_ready;
        if (m_init) begin
            chk("grant", 32'(grant), 32'(eg));
            chk("release_cause", 32'(release_cause), 32'(m_cause));
            chk("uart_in_valid", 32'(uart_in_valid), 32'(xv));
            chk("uart_in_data", 32'(uart_in_data), 32'(xd));
            chk("a_ready", 32'(a_ready), 32'((m_owner == 1) && uart_in_ready));
            chk("b_ready", 32'(b_ready), 32'((m_owner == 2) && uart_in_ready));
            if (prev_grant != 2'b00 && grant == 2'b00 && !prev_rst)
                rel_cnt[release_cause]++;
            if (xfer) begin
                checks++;
                if (m_owner == 1 && exp_a.size() != 0) e = exp_a.pop_front();
                else if (m_owner == 2 && exp_b.size() != 0) e = exp_b.pop_front();
                else e = 8'hxx;
                if (uart_in_data !== e) begin
                    failures++;
                    $display("FAIL byte_order owner=%0d actual=%0h required=%0h t=%0t",
                             m_owner, uart_in_data, e, $time);
                end
            end
        end
        prev_grant = grant;
        prev_rst = reset;
        if (reset) begin
            m_init = 1;
            m_owner = 0;
            m_last_b = 1;
            m_cause = 2'b00;
        end else if (m_owner == 0) begin
            m_burst = 0;
            m_idle = 0;
            if (a_valid && b_valid) m_owner = m_last_b ? 1 : 2;
            else if (a_valid) m_owner = 1;
            else if (b_valid) m_owner = 2;
        end else begin
            int c;
            c = 0;
            if (xv) m_idle = 0;
            if (xfer) begin
                m_burst++;
                if (xd == 8'h0A) c = 1;
                else if (m_burst == MAXB) c = 2;
            end else if (!xv) begin
                m_idle++;
                if (m_idle == TOUT) c = 3;
            end
            if (c != 0) begin
                m_last_b = (m_owner == 2);
                m_owner = 0;
                m_cause = 2'(c);
            end
        end
    end

    // Requester and sink drivers: hold each byte until its handshake
    always @(posedge clk) begin
        #1;
        if (acc_a) begin
            void'(src_a.pop_front());
            a_valid = 1'b0;
        end
        if (acc_b) begin
            void'(src_b.pop_front());
            b_valid = 1'b0;
        end
        if (!a_valid && src_a.size() != 0 && int'($urandom_range(99)) < rate_a) begin
            a_valid = 1'b1;
            a_data = src_a[0];
        end
        if (!b_valid && src_b.size() != 0 && int'($urandom_range(99)) < rate_b) begin
            b_valid = 1'b1;
            b_data = src_b[0];
        end
        uart_in_ready = (rdy_mode == 1) ? 1'b1 :
                        (rdy_mode == 0) ? 1'b0 : ($urandom_range(3) != 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b1, b2, b3;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(2);

        // Tie after reset: A first, newline release, then B
        rdy_mode = 1;
        push_a(8'h11); push_a(8'h22); push_a(8'h0A);
        push_b(8'h33); push_b(8'h44); push_b(8'h0A);
        wait_drain(200, "tie");
        chk("tie_newline_releases", 32'(rel_cnt[1]), 32'd2);

        // Burst limit: 200 bytes from A alone
        b2 = rel_cnt[2];
        for (int i = 0; i < 200; i++) push_a(rnd_plain());
        wait_drain(2000, "burst");
        chk("burst_releases", 32'(rel_cnt[2] - b2), 32'd3);

        // Timeout with B waiting
        b3 = rel_cnt[3];
        push_a(8'h01); push_a(8'h02); push_a(8'h03);
        wait_grant(2'b01, "timeout_grant_a");
        push_b(8'hB1); push_b(8'hB2); push_b(8'h0A);
        wait_drain(500, "timeout");
        chk("timeout_releases", 32'(rel_cnt[3] - b3), 32'd1);

        // Backpressure: long stall holds the grant
        rdy_mode = 0;
        push_a(8'h55); push_a(8'h0A);
        step(3);
        push_b(8'h66); push_b(8'h0A);
        step(10000);
        chk("bp_grant_held", 32'(grant), 32'h1);
        chk("bp_b_ready", 32'(b_ready), 32'h0);
        rdy_mode = 1;
        wait_drain(500, "backpressure");

        // Reset in the middle of B's burst, A then wins the tie
        for (int i = 0; i < 20; i++) push_b(rnd_plain());
        push_b(8'h0A);
        wait_grant(2'b10, "rst_grant_b");
        step(5);
        reset = 1'b1;
        push_a(8'h77); push_a(8'h0A);
        step(1);
        reset = 1'b0;
        wait_grant(2'b01, "rst_a_first");
        wait_drain(1000, "reset_mid");

        // Newline coinciding with the burst limit
        b1 = rel_cnt[1];
        b2 = rel_cnt[2];
        for (int i = 0; i < 63; i++) push_a(rnd_plain());
        push_a(8'h0A);
        wait_drain(500, "nl_limit");
        chk("nl_limit_cause_nl", 32'(rel_cnt[1] - b1), 32'd1);
        chk("nl_limit_no_burst", 32'(rel_cnt[2] - b2), 32'd0);

        // Randomised traffic
        rdy_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(9) < 3)
                push_a(($urandom_range(7) == 0) ? 8'h0A : 8'($urandom_range(255)));
            if ($urandom_range(9) < 3)
                push_b(($urandom_range(7) == 0) ? 8'h0A : 8'($urandom_range(255)));
            if (c % 200 == 0) begin
                rate_a = 30 + int'($urandom_range(70));
                rate_b = 30 + int'($urandom_range(70));
            end
            step(1);
        end
        rdy_mode = 1;
        rate_a = 100;
        rate_b = 100;
        wait_drain(20000, "random");
        chk("exp_a_empty", 32'(exp_a.size()), 32'd0);
        chk("exp_b_empty", 32'(exp_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
